// File: rtl/iir_pkg.sv
// Shared types and arithmetic helpers for the multi-channel biquad.
// Saturation and rounding work on a wide signed carrier type.
package iir_pkg;

    typedef enum logic [2:0] {
        IDLE, B0, Y, B1, A1, B2, A2, OUT
    } state_t;

    localparam int WIDE = 128;
    typedef logic signed [WIDE-1:0] wide_t;

    function automatic int acc_w(input int dw, input int cw);
        return dw + cw + 2;
    endfunction

    function automatic wide_t sat(input wide_t v, input int w);
        wide_t hi;
        wide_t lo;
        hi = (wide_t'(1) <<< (w - 1)) - wide_t'(1);
        lo = -hi - wide_t'(1);
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

    function automatic wide_t rnd_shr(input wide_t v, input int f);
        return (v + (wide_t'(1) <<< (f - 1))) >>> f;
    endfunction

endpackage

// File: rtl/iir_biquad_mc_if.sv
// Sample stream bundle: input and output valid/ready channels
// with a channel tag on each side.
interface iir_biquad_mc_if #(
    parameter int DW  = 16,
    parameter int CHW = 1
);
    logic                  in_valid;
    logic                  in_ready;
    logic signed [DW-1:0]  in_data;
    logic [CHW-1:0]        in_ch;
    logic                  out_valid;
    logic                  out_ready;
    logic signed [DW-1:0]  out_data;
    logic [CHW-1:0]        out_ch;

    modport master (
        output in_valid, in_data, in_ch, out_ready,
        input  in_ready, out_valid, out_data, out_ch
    );

    modport slave (
        input  in_valid, in_data, in_ch, out_ready,
        output in_ready, out_valid, out_data, out_ch
    );
endinterface

// File: rtl/iir_mac.sv
// Shared signed multiply-accumulate; the only multiplier in the filter.
// nxt is the combinational result, acc its registered copy.
module iir_mac #(
    parameter int CW = 18,
    parameter int DW = 16,
    parameter int MW = 38
) (
    input  logic                 clk,
    input  logic                 en,
    input  logic                 sub,
    input  logic signed [MW-1:0] base,
    input  logic signed [CW-1:0] coef,
    input  logic signed [DW-1:0] dat,
    output logic signed [MW-1:0] nxt,
    output logic signed [MW-1:0] acc
);
    logic signed [CW+DW-1:0] prod;

    assign prod = (CW+DW)'(coef) * (CW+DW)'(dat);
    assign nxt  = sub ? base - MW'(prod) : base + MW'(prod);

    // Capture the accumulation on every active step
    always_ff @(posedge clk) begin
        if (en) acc <= nxt;
    end
endmodule

// File: rtl/iir_biquad_mc.sv
// Time-multiplexed transposed DF-II biquad with per-channel state.
// One FSM step per cycle drives the shared MAC.
module iir_biquad_mc
    import iir_pkg::*;
#(
    parameter int DW       = 16,
    parameter int CW       = 18,
    parameter int CHANNELS = 2,
    parameter int CHW      = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic signed [CW-1:0] b0,
    input  logic signed [CW-1:0] b1,
    input  logic signed [CW-1:0] b2,
    input  logic signed [CW-1:0] a1,
    input  logic signed [CW-1:0] a2,
    iir_biquad_mc_if.slave       io
);
    localparam int AW = acc_w(DW, CW);
    localparam int MW = AW + 2;
    localparam int F  = CW - 2;

    state_t st;
    logic rdy_q, ov_q, byp_q, in_byp;
    logic signed [DW-1:0] x_q, y_q, od_q, y_nxt;
    logic [CHW-1:0] ch_q, oc_q;
    logic signed [CW-1:0] c_b0, c_b1, c_b2, c_a1, c_a2;
    logic signed [AW-1:0] s1_q, s2_q, s1_rd, s2_rd, s_nxt;
    logic signed [AW-1:0] s1_mem [CHANNELS];
    logic signed [AW-1:0] s2_mem [CHANNELS];
    logic m_en, m_sub;
    logic signed [MW-1:0] m_base, m_nxt, m_acc;
    logic signed [CW-1:0] m_coef;
    logic signed [DW-1:0] m_dat;

    assign io.in_ready  = rdy_q & ~clear;
    assign io.out_valid = ov_q;
    assign io.out_data  = od_q;
    assign io.out_ch    = oc_q;
    assign in_byp = int'(io.in_ch) >= CHANNELS;

    assign y_nxt = DW'(sat(rnd_shr(wide_t'(m_acc), F), DW));
    assign s_nxt = AW'(sat(wide_t'(m_nxt), AW));

    // Fetch the tagged channel's state; bypass tags read as zero
    always_comb begin
        s1_rd = '0;
        s2_rd = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (io.in_ch == CHW'(i)) begin
                s1_rd = s1_mem[i];
                s2_rd = s2_mem[i];
            end
        end
    end

    // Route operands of the current step to the shared MAC
    always_comb begin
        m_en   = 1'b0;
        m_sub  = 1'b0;
        m_base = '0;
        m_coef = c_b0;
        m_dat  = x_q;
        unique case (st)
            B0: begin
                m_en   = 1'b1;
                m_base = MW'(s1_q);
            end
            B1: begin
                m_en   = 1'b1;
                m_base = MW'(s2_q);
                m_coef = c_b1;
            end
            A1: begin
                m_en   = 1'b1;
                m_sub  = 1'b1;
                m_base = m_acc;
                m_coef = c_a1;
                m_dat  = y_q;
            end
            B2: begin
                m_en   = 1'b1;
                m_coef = c_b2;
            end
            A2: begin
                m_en   = 1'b1;
                m_sub  = 1'b1;
                m_base = m_acc;
                m_coef = c_a2;
                m_dat  = y_q;
            end
            default: ;
        endcase
    end

    iir_mac #(.CW(CW), .DW(DW), .MW(MW)) u_mac (
        .clk  (clk),
        .en   (m_en),
        .sub  (m_sub),
        .base (m_base),
        .coef (m_coef),
        .dat  (m_dat),
        .nxt  (m_nxt),
        .acc  (m_acc)
    );

    // Sequencer, state write-back and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            st    <= IDLE;
            rdy_q <= 1'b0;
            ov_q  <= 1'b0;
            od_q  <= '0;
            oc_q  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_mem[i] <= '0;
                s2_mem[i] <= '0;
            end
        end else if (clear) begin
            st    <= IDLE;
            rdy_q <= 1'b1;
            ov_q  <= 1'b0;
            for (int i = 0; i < CHANNELS; i++) begin
                s1_mem[i] <= '0;
                s2_mem[i] <= '0;
            end
        end else begin
            unique case (st)
                IDLE: begin
                    rdy_q <= 1'b1;
                    if (io.in_valid && rdy_q) begin
                        x_q   <= io.in_data;
                        ch_q  <= io.in_ch;
                        byp_q <= in_byp;
                        c_b0  <= b0;
                        c_b1  <= b1;
                        c_b2  <= b2;
                        c_a1  <= a1;
                        c_a2  <= a2;
                        s1_q  <= s1_rd;
                        s2_q  <= s2_rd;
                        rdy_q <= 1'b0;
                        st    <= B0;
                    end
                end
                B0: st <= Y;
                Y: begin
                    y_q <= byp_q ? x_q : y_nxt;
                    st  <= B1;
                end
                B1: st <= A1;
                A1: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!byp_q && ch_q == CHW'(i)) s1_mem[i] <= s_nxt;
                    end
                    st <= B2;
                end
                B2: st <= A2;
                A2: begin
                    for (int i = 0; i < CHANNELS; i++) begin
                        if (!byp_q && ch_q == CHW'(i)) s2_mem[i] <= s_nxt;
                    end
                    ov_q <= 1'b1;
                    od_q <= y_q;
                    oc_q <= ch_q;
                    st   <= OUT;
                end
                OUT: begin
                    if (io.out_ready) begin
                        ov_q  <= 1'b0;
                        rdy_q <= 1'b1;
                        st    <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule
